// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch bus bridges.
// Contents:
//   bridge_state_e - AXI read bridge state encoding
//   AXI_RESP_OKAY  - AXI4 OKAY response code
//   ARPROT_INST    - arprot for instruction, unprivileged, secure accesses
//   NOP_INST       - instruction word substituted on any fetch error
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } bridge_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0]  ARPROT_INST   = 3'b100;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

endpackage

// File: rtl/rd_watchdog.sv
// Saturating response watchdog for bus read bridges.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - count this cycle (bridge is waiting for read data)
//   clr        - restart the count from zero
//   expired    - high in the enabled cycle where the count reaches TIMEOUT-1
// TIMEOUT = 0 disables the watchdog (expired never asserts).
module rd_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (TIMEOUT != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ifu_axi_rd_bridge.sv
// Bridge from the instruction fetch unit's pulse handshake to one AXI4-Lite
// read. A reqValid pulse with pc launches a read; a respValid pulse returns
// the instruction word and an error flag (misaligned pc, rresp != OKAY, or
// watchdog timeout, all of which return ERR_INST).
// Ports:
//   clock, reset             - clock, asynchronous active-low reset
//   reqValid, pc             - fetch request from the IFU
//   respValid, inst, resp_err - fetch response (inst/resp_err held between pulses)
//   busy                     - request outstanding
//   ar*/r*                   - AXI4-Lite read address / read data channels
module ifu_axi_rd_bridge
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_INST = NOP_INST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic [ADDR_W-1:0] pc,
    output logic              respValid,
    output logic [DATA_W-1:0] inst,
    output logic              resp_err,
    output logic              busy,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    bridge_state_e     state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              resp_err_q, resp_err_d;
    logic              wd_en, wd_clr, wd_expired;

    rd_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clock),
        .rst_n   (reset),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        araddr_d     = araddr_q;
        resp_valid_d = 1'b0;
        inst_d       = inst_q;
        resp_err_d   = resp_err_q;
        wd_en        = 1'b0;
        wd_clr       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (reqValid) begin
                    if (pc[1:0] != 2'b00) begin
                        // No bus access; the pulse is issued on leaving RESP.
                        inst_d     = ERR_INST;
                        resp_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        araddr_d  = pc;
                        arvalid_d = 1'b1;
                        state_d   = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    wd_clr    = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                wd_en = 1'b1;
                if (rvalid) begin
                    inst_d       = (rresp == AXI_RESP_OKAY) ? rdata : ERR_INST;
                    resp_err_d   = (rresp != AXI_RESP_OKAY);
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (wd_expired) begin
                    inst_d       = ERR_INST;
                    resp_err_d   = 1'b1;
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                // Bus responses enter RESP with the pulse already raised; a
                // misaligned request enters with it low and raises it here,
                // giving one pulse per request in both cases.
                resp_valid_d = ~resp_valid_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            araddr_q     <= '0;
            resp_valid_q <= 1'b0;
            inst_q       <= ERR_INST;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            araddr_q     <= araddr_d;
            resp_valid_q <= resp_valid_d;
            inst_q       <= inst_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign respValid = resp_valid_q;
    assign inst      = inst_q;
    assign resp_err  = resp_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign arvalid   = arvalid_q;
    assign araddr    = araddr_q;
    assign arprot    = ARPROT_INST;
    assign rready    = rready_q;

endmodule

// File: tb/tb_ifu_axi_rd_bridge.sv
// Directed self-checking bench for ifu_axi_rd_bridge (TIMEOUT = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ifu_axi_rd_bridge;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic [31:0] pc;
    logic        respValid;
    logic [31:0] inst;
    logic        resp_err;
    logic        busy;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-transaction observations filled by run_txn.
    int          lat;
    int          n_ar;
    int          n_resp;
    int          ar_low;
    bit          ar_ok;
    bit          saw_ar;
    bit          rready_after;
    bit          busy1;
    logic [31:0] got_inst;
    logic        got_err;

    ifu_axi_rd_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .reqValid  (reqValid),
        .pc        (pc),
        .respValid (respValid),
        .inst      (inst),
        .resp_err  (resp_err),
        .busy      (busy),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arprot    (arprot),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request at the current falling edge and plays the AXI slave:
    // arready after ar_wait cycles of arvalid, rvalid in the first cycle rready
    // is seen (unless no_r). Optionally pokes a second reqValid at k=2.
    task automatic run_txn(input logic [31:0] a, input int ar_wait, input logic [31:0] d,
                           input logic [1:0] rr, input bit no_r, input bit poke);
        int  waited = 0;
        bit  r_sent = 0;
        bit  hs     = 0;
        lat = -1; n_ar = 0; n_resp = 0; ar_low = 0;
        ar_ok = 1; saw_ar = 0; rready_after = 0; busy1 = 0;
        got_inst = 'x; got_err = 'x;
        reqValid = 1'b1; pc = a; arready = 1'b0; rvalid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            reqValid = 1'b0;
            if (k == 1) busy1 = busy;
            if (respValid) begin
                n_resp++;
                if (lat < 0) begin
                    lat = k; got_inst = inst; got_err = resp_err;
                end
            end
            if (lat > 0 && rready) rready_after = 1;
            if (arvalid) begin
                saw_ar = 1;
                if (araddr !== a) ar_ok = 0;
                if (waited < ar_wait) begin
                    arready = 1'b0; waited++; ar_low++;
                end else begin
                    arready = 1'b1; n_ar++; hs = 1;
                end
            end else begin
                if (saw_ar && !hs) ar_ok = 0;
                arready = 1'b0;
            end
            if (rready && !r_sent && !no_r) begin
                rvalid = 1'b1; rdata = d; rresp = rr; r_sent = 1;
            end else begin
                rvalid = 1'b0;
            end
            if (poke && k == 2) begin
                reqValid = 1'b1; pc = 32'h8000_0F00;
            end
            if (lat > 0 && k >= lat + 3) break;
        end
        arready = 1'b0; rvalid = 1'b0; reqValid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; reqValid = 1'b0; pc = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (2) @(negedge clock);

        check_eq("rst_arvalid",   arvalid,   0);
        check_eq("rst_rready",    rready,    0);
        check_eq("rst_araddr",    araddr,    0);
        check_eq("rst_respValid", respValid, 0);
        check_eq("rst_inst",      inst,      32'h0000_0013);
        check_eq("rst_resp_err",  resp_err,  0);
        check_eq("rst_busy",      busy,      0);
        check_eq("arprot",        arprot,    3'b100);
        reset = 1'b1;
        @(negedge clock);

        // Reset while in DATA with rvalid pending.
        reqValid = 1'b1; pc = 32'h8000_0010; arready = 1'b1;
        @(negedge clock);
        reqValid = 1'b0;
        check_eq("t1_arvalid_addr", arvalid, 1);
        @(negedge clock);
        check_eq("t1_rready_data", rready, 1);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; reset = 1'b0;
        #1;
        check_eq("t1_async_busy",    busy,    0);
        check_eq("t1_async_arvalid", arvalid, 0);
        check_eq("t1_async_rready",  rready,  0);
        @(negedge clock);
        check_eq("t1_busy",      busy,      0);
        check_eq("t1_respValid", respValid, 0);
        check_eq("t1_rready",    rready,    0);
        check_eq("t1_inst",      inst,      32'h0000_0013);
        reset = 1'b1; rvalid = 1'b0; arready = 1'b0;
        @(negedge clock);

        // Zero-wait slave.
        run_txn(32'h8000_0004, 0, 32'h0050_0093, 2'b00, 0, 0);
        check_eq("t2_lat",    lat,      3);
        check_eq("t2_araddr", ar_ok,    1);
        check_eq("t2_n_ar",   n_ar,     1);
        check_eq("t2_n_resp", n_resp,   1);
        check_eq("t2_inst",   got_inst, 32'h0050_0093);
        check_eq("t2_err",    got_err,  0);
        check_eq("t2_hold",   inst,     32'h0050_0093);

        // arready held low 5 cycles, stray reqValid while busy.
        run_txn(32'h8000_0100, 5, 32'h1234_5678, 2'b00, 0, 1);
        check_eq("t3_lat",    lat,      8);
        check_eq("t3_stable", ar_ok,    1);
        check_eq("t3_ar_low", ar_low,   5);
        check_eq("t3_n_ar",   n_ar,     1);
        check_eq("t3_n_resp", n_resp,   1);
        check_eq("t3_inst",   got_inst, 32'h1234_5678);

        // SLVERR.
        run_txn(32'h8000_0020, 0, 32'hCAFE_F00D, 2'b10, 0, 0);
        check_eq("t4_lat",  lat,      3);
        check_eq("t4_inst", got_inst, 32'h0000_0013);
        check_eq("t4_err",  got_err,  1);

        // Misaligned pc.
        run_txn(32'h8000_0002, 0, 32'h1111_1111, 2'b00, 0, 0);
        check_eq("t5_no_ar",  saw_ar,   0);
        check_eq("t5_busy",   busy1,    1);
        check_eq("t5_lat",    lat,      2);
        check_eq("t5_n_resp", n_resp,   1);
        check_eq("t5_inst",   got_inst, 32'h0000_0013);
        check_eq("t5_err",    got_err,  1);

        // Watchdog: no R beat ever.
        run_txn(32'h8000_0008, 0, 32'h2222_2222, 2'b00, 1, 0);
        check_eq("t6_lat",          lat,          10);
        check_eq("t6_inst",         got_inst,     32'h0000_0013);
        check_eq("t6_err",          got_err,      1);
        check_eq("t6_rready_after", rready_after, 0);
        check_eq("t6_n_resp",       n_resp,       1);

        // Normal request after the timeout.
        run_txn(32'h8000_000C, 0, 32'h00A0_0113, 2'b00, 0, 0);
        check_eq("t7_lat",  lat,      3);
        check_eq("t7_inst", got_inst, 32'h00A0_0113);
        check_eq("t7_err",  got_err,  0);
        check_eq("t7_busy", busy,     0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_axi_rd_bridge.md
Name: ifu_axi_rd_bridge

Overview:
Sits directly downstream of the instruction fetch unit.
- Takes the fetch unit's single-cycle reqValid pulse plus the PC.
- Issues one AXI4-Lite read (AR/R channels) to instruction memory.
- Returns a single-cycle respValid pulse with the captured instruction word and error flag.
- Adds misalignment check and a response watchdog so a stuck slave cannot hang the fetch FSM.

Parameters:
ADDR_W, 32, address width of pc and araddr
DATA_W, 32, instruction/rdata width
TIMEOUT, 255, max cycles waiting in DATA before forced error response; 0 disables watchdog
ERR_INST, 32'h0000_0013, instruction word returned on any error (NOP)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
reqValid  in  1  fetch request pulse from IFU (one cycle)
pc  in  ADDR_W  fetch address, valid with reqValid
respValid  out  1  one-cycle pulse: inst/resp_err valid
inst  out  DATA_W  fetched instruction, held until next respValid
resp_err  out  1  1 = misaligned, bus error (rresp!=OKAY) or timeout
busy  out  1  request outstanding (state != IDLE)
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
araddr  out  ADDR_W  AXI read address
arprot  out  3  constant 3'b100 (instruction, unprivileged, secure)
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
rdata  in  DATA_W  AXI read data
rresp  in  2  AXI read response

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, arvalid=0, rready=0, araddr=0, respValid=0, inst=ERR_INST, resp_err=0, timer=0.
- All outputs registered except busy (decoded from state) and arprot (constant).
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - reqValid & pc[1:0]!=0 -> RESP; inst=ERR_INST, resp_err=1; no bus access.
  - reqValid & aligned -> ADDR; araddr=pc, arvalid=1 from next cycle.
- ADDR:
  - arvalid held high, araddr stable until arvalid&arready.
  - On handshake: arvalid=0, rready=1, timer=0 -> DATA.
- DATA:
  - rready=1.
  - rvalid -> capture inst=rdata (ERR_INST if rresp!=2'b00), resp_err=(rresp!=0), rready=0 -> RESP.
  - else timer++; timer==TIMEOUT-1 with no rvalid (TIMEOUT!=0) -> inst=ERR_INST, resp_err=1, rready=0 -> RESP.
  - Late R beats after timeout: none consumed (rready=0); slave is considered broken; no recovery beyond reset.
- RESP: respValid=1 for exactly one cycle -> IDLE.
- Latency, zero-wait slave (arready=1, rvalid the cycle after AR): reqValid at cycle N, arvalid N+1, rvalid N+2, respValid N+3.
- Misaligned latency: reqValid N -> respValid N+2.
- reqValid while busy: ignored (IFU protocol forbids it); pc not re-latched.
- reqValid in RESP cycle: ignored.
- Simultaneous arready and rvalid in ADDR: rvalid ignored until DATA (rready=0 in ADDR).
- Reset mid-transaction: immediate return to IDLE, handshake outputs dropped; bus side is the slave's concern.
- Timer width: $clog2(TIMEOUT+1); saturating, never wraps.
- inst/resp_err change only when entering RESP; stable otherwise.

Decomposition:
- Shared package ifu_pkg:
  - bridge state enum (IDLE, ADDR, DATA, RESP)
  - AXI_RESP_OKAY=2'b00
  - ARPROT_INST=3'b100
  - default NOP constant 32'h0000_0013
- Optional sub-module rd_watchdog (enable/clear, counter, expired flag), reusable by the future LSU bridge.
- Otherwise single module.

Test Plan:
1. reset low mid-DATA with rvalid pending -> next cycle state IDLE, arvalid=0, rready=0, respValid=0, busy=0.
2. Zero-wait slave, reqValid with pc=32'h8000_0004, rdata=32'h00500093, rresp=0 -> araddr=32'h8000_0004; respValid at N+3; inst=32'h00500093, resp_err=0.
3. arready low 5 cycles -> arvalid and araddr held stable all 5 cycles; exactly one AR handshake; respValid once.
4. rresp=2'b10 (SLVERR) -> respValid, inst=32'h00000013, resp_err=1.
5. pc=32'h8000_0002 -> no arvalid ever; respValid at N+2, resp_err=1, inst=32'h00000013.
6. TIMEOUT=8, rvalid never -> respValid 8 cycles after entering DATA; resp_err=1; rready low afterwards; a following aligned request then completes normally.
